// File: rtl/seq_shifter.sv
// Multi-cycle log shifter: one stage per clock, start/busy/done handshake, rotates and error flag.
// Define SEQ_SHIFTER_CARRY_EN to add the o_carry output.
module seq_shifter #(
  parameter int WIDTH       = 32,
  parameter int SHIFT_WIDTH = $clog2(WIDTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [WIDTH-1:0]       i_data,
  input  logic [SHIFT_WIDTH-1:0] i_shift,
  input  logic [2:0]             i_op,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [WIDTH-1:0]       o_result,
  output logic                   o_err
`ifdef SEQ_SHIFTER_CARRY_EN
  ,
  output logic                   o_carry
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SHIFT_WIDTH-1:0] LAST = SHIFT_WIDTH'(SHIFT_WIDTH - 1);
  localparam logic [WIDTH-1:0]       ONES = '1;

  state_t                 state, state_nxt;
  logic [WIDTH-1:0]       work, work_nxt;
  logic [SHIFT_WIDTH-1:0] shamt, stage;
  logic [2:0]             op;
  logic                   fill;
  logic                   accept, last, invalid;

  assign accept  = i_start && (state != SHIFT);
  assign last    = (state == SHIFT) && (stage == LAST);
  assign invalid = op[2] & op[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state == SHIFT);
    o_done = (state == DONE);
  end

  // Only the stage selected by the counter is live; each has a constant distance 2**s.
  always_comb begin
    work_nxt = work;
    for (int s = 0; s < SHIFT_WIDTH; s++) begin
      if (stage == SHIFT_WIDTH'(s) && shamt[s]) begin
        case (op)
          3'b000, 3'b001: work_nxt = work << (1 << s);
          3'b010:         work_nxt = (work >> (1 << s)) | (fill ? ~(ONES >> (1 << s)) : '0);
          3'b011:         work_nxt = work >> (1 << s);
          3'b100:         work_nxt = (work << (1 << s)) | (work >> (WIDTH - (1 << s)));
          3'b101:         work_nxt = (work >> (1 << s)) | (work << (WIDTH - (1 << s)));
          default:        work_nxt = work;
        endcase
      end
    end
  end

`ifdef SEQ_SHIFTER_CARRY_EN
  // Carry comes straight from the operand: bit WIDTH-shamt for left moves, bit shamt-1 for right.
  logic [WIDTH:0] lsl_ext, rsh_ext;
  logic           carry_acc, carry_w;

  always_comb begin
    lsl_ext = {1'b0, i_data} << i_shift;
    rsh_ext = {i_data, 1'b0} >> i_shift;
    case (i_op)
      3'b000, 3'b001, 3'b100: carry_acc = lsl_ext[WIDTH];
      3'b010, 3'b011, 3'b101: carry_acc = rsh_ext[0];
      default:                carry_acc = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      carry_w <= 1'b0;
      o_carry <= 1'b0;
    end else begin
      if (accept)    carry_w <= carry_acc;
      else if (last) o_carry <= carry_w;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      work     <= '0;
      shamt    <= '0;
      stage    <= '0;
      op       <= '0;
      fill     <= 1'b0;
      o_result <= '0;
      o_err    <= 1'b0;
    end else if (accept) begin
      work  <= i_data;
      shamt <= i_shift;
      op    <= i_op;
      fill  <= (i_op == 3'b010) & i_data[WIDTH-1];
      stage <= '0;
    end else if (state == SHIFT) begin
      work  <= work_nxt;
      stage <= stage + SHIFT_WIDTH'(1);
      if (last) begin
        o_result <= work_nxt;
        o_err    <= invalid;
      end
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: cycle-level reference model plus literal checks of the documented cases.
module tb_seq_shifter;
  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 0, rst_n = 0, start = 0;
  logic [W-1:0]  data = '0;
  logic [SW-1:0] sh = '0;
  logic [2:0]    op = '0;
  logic          busy, done, err;
  logic [W-1:0]  result;
`ifdef SEQ_SHIFTER_CARRY_EN
  logic          carry;
`endif

  seq_shifter #(.WIDTH(W), .SHIFT_WIDTH(SW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_data(data), .i_shift(sh), .i_op(op),
    .o_busy(busy), .o_done(done), .o_result(result), .o_err(err)
`ifdef SEQ_SHIFTER_CARRY_EN
    , .o_carry(carry)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {err, carry, result} from the plain arithmetic meaning of each op.
  function automatic logic [W+1:0] ref_op(input logic [2:0] o, input logic [W-1:0] d, input int s);
    logic [W-1:0] r;
    logic c;
    r = d;
    c = 1'b0;
    case (o)
      3'd0, 3'd1: begin r = d << s; if (s > 0) c = d[W-s]; end
      3'd2: begin r = $signed(d) >>> s; if (s > 0) c = d[s-1]; end
      3'd3: begin r = d >> s; if (s > 0) c = d[s-1]; end
      3'd4: begin r = (d << s) | (d >> (W - s)); if (s > 0) c = r[0]; end
      3'd5: begin r = (d >> s) | (d << (W - s)); if (s > 0) c = r[W-1]; end
      default: ;
    endcase
    return {(o >= 3'd6), c, r};
  endfunction

  // Model: an accepted op completes SW edges later; outputs hold between completions.
  int           rem = 0;
  logic         m_done = 0, m_err = 0, m_carry = 0, acc;
  logic [W-1:0] m_res = '0;
  logic [W+1:0] pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem = 0; m_done = 0; m_err = 0; m_carry = 0; m_res = '0;
    end else begin
      acc = (rem == 0) && start;
      m_done = 0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          m_done = 1; m_res = pend[W-1:0]; m_carry = pend[W]; m_err = pend[W+1];
        end
      end
      if (acc) begin
        rem = SW;
        pend = ref_op(op, data, int'(sh));
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", W'(busy), W'(rem > 0));
    chk("done", W'(done), W'(m_done));
    chk("result", result, m_res);
    chk("err", W'(err), W'(m_err));
`ifdef SEQ_SHIFTER_CARRY_EN
    chk("carry", W'(carry), W'(m_carry));
`endif
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] d, input int s, input bit now);
    if (!now) @(negedge clk);
    start = 1; op = o; data = d; sh = SW'(s);
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (!done && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s: no done within %0d cycles", name, n);
    end
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [W-1:0] d, input int s,
                     input logic [W-1:0] exp_r, input logic exp_e, input logic exp_c, input bit now);
    int n;
    issue(o, d, s, now);
    wait_done(name, n);
    chk({name, " latency"}, W'(n), W'(SW));
    chk({name, " result"}, result, exp_r);
    chk({name, " err"}, W'(err), W'(exp_e));
`ifdef SEQ_SHIFTER_CARRY_EN
    chk({name, " carry"}, W'(carry), W'(exp_c));
`else
    if (exp_c === 1'bx) $display("unexpected x carry literal");
`endif
  endtask

  initial begin
    int n, cnt;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("reset busy", W'(busy), '0);
    chk("reset done", W'(done), '0);
    chk("reset result", result, 32'h0000_0000);

    run("lsl31", 3'b000, 32'h0000_0001, 31, 32'h8000_0000, 0, 0, 0);
    run("asr_neg", 3'b010, 32'h8000_0000, 4, 32'hF800_0000, 0, 0, 0);
    run("lsr", 3'b011, 32'h8000_0000, 4, 32'h0800_0000, 0, 0, 0);
    run("asr_pos", 3'b010, 32'h7000_0000, 4, 32'h0700_0000, 0, 0, 0);
    run("ror1", 3'b101, 32'h0000_0001, 1, 32'h8000_0000, 0, 1, 0);
    run("rol4", 3'b100, 32'h8000_0001, 4, 32'h0000_0018, 0, 0, 0);
    run("shift0", 3'b001, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 0, 0);
    run("invalid", 3'b111, 32'h1234_5678, 5, 32'h1234_5678, 1, 0, 0);
    run("b2b_clear_err", 3'b000, 32'h0000_0003, 2, 32'h0000_000C, 0, 0, 1);
    run("b2b_lsr", 3'b011, 32'h0000_00F0, 4, 32'h0000_000F, 0, 0, 1);

    // Start while busy must be dropped.
    issue(3'b000, 32'h0000_0001, 31, 0);
    start = 1; op = 3'b000; data = 32'hFFFF_FFFF; sh = 5'd1;
    @(negedge clk);
    start = 0;
    wait_done("ignored", n);
    chk("ignored result", result, 32'h8000_0000);
    count_done(8, cnt);
    chk("ignored extra done", W'(cnt), '0);

    // Reset in the middle of an op.
    issue(3'b011, 32'hFFFF_FFFF, 3, 0);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort busy", W'(busy), '0);
    chk("abort done", W'(done), '0);
    chk("abort result", result, '0);
    chk("abort err", W'(err), '0);
    @(negedge clk);
    rst_n = 1;
    count_done(10, cnt);
    chk("abort no done", W'(cnt), '0);

    repeat (600) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      op    = 3'($urandom_range(0, 7));
      data  = $urandom;
      sh    = SW'($urandom_range(0, W - 1));
    end
    @(negedge clk);
    start = 0;
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
